// File: rtl/cnu_min_seq.sv
// ----------------------------------------------------------------------------
// cnu_min_seq
// Serial min-sum check-node unit. It accepts one variable-to-check message per
// beat for a row of `deg` messages and reports the two smallest magnitudes,
// the beat position of the smallest, and the XOR of all signs.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   start      : begin a row (honoured only in IDLE)
//   deg        : row degree, sampled with start; legal range 2 .. 2**IDX_W
//   in_valid   : message beat valid
//   in_ready   : high while accumulating (state ACC)
//   in_mag     : message magnitude, unsigned
//   in_sgn     : message sign
//   out_valid  : row result valid (state HOLD)
//   out_ready  : consumer accepts the result
//   min1/min2  : smallest / second-smallest magnitude of the row
//   idx        : 0-based beat position of min1 (earliest on ties)
//   sgn_prod   : XOR of all row signs
//   busy       : high whenever the state is not IDLE
//   err        : one-cycle pulse when start carries an illegal degree
// ----------------------------------------------------------------------------
module cnu_min_seq #(
    parameter int DATA_W = 9,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W:0]    deg,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mag,
    input  logic              in_sgn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] min1,
    output logic [DATA_W-1:0] min2,
    output logic [IDX_W-1:0]  idx,
    output logic              sgn_prod,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [IDX_W:0]    DEG_MIN  = (IDX_W+1)'(2);
    localparam logic [IDX_W:0]    DEG_MAX  = {1'b1, {IDX_W{1'b0}}};
    localparam logic [DATA_W-1:0] MAG_ONES = {DATA_W{1'b1}};

    state_t              r_state;
    logic [IDX_W:0]      r_last;     // latched deg-1, the position of the final beat
    logic [IDX_W-1:0]    r_cnt;      // position of the next beat to arrive
    logic [DATA_W-1:0]   r_min1;
    logic [DATA_W-1:0]   r_min2;
    logic [IDX_W-1:0]    r_idx;
    logic                r_sgn;
    logic                r_err;

    logic                w_deg_ok;
    logic [IDX_W:0]      w_deg_m1;
    logic                w_last_beat;

    assign w_deg_ok    = (deg >= DEG_MIN) && (deg <= DEG_MAX);
    assign w_deg_m1    = deg - (IDX_W+1)'(1);
    assign w_last_beat = ({1'b0, r_cnt} == r_last);

    // Row FSM together with the running min1/min2/idx/sign accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= '0;
            r_cnt   <= '0;
            r_min1  <= MAG_ONES;
            r_min2  <= MAG_ONES;
            r_idx   <= '0;
            r_sgn   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_deg_ok) begin
                            r_last  <= w_deg_m1;
                            r_cnt   <= '0;
                            r_min1  <= MAG_ONES;
                            r_min2  <= MAG_ONES;
                            r_idx   <= '0;
                            r_sgn   <= 1'b0;
                            r_state <= ST_ACC;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (in_valid) begin
                        // Strict compares: a tie with min1 only refreshes min2,
                        // so idx keeps the earliest position of the minimum.
                        if (in_mag < r_min1) begin
                            r_min2 <= r_min1;
                            r_min1 <= in_mag;
                            r_idx  <= r_cnt;
                        end else if (in_mag < r_min2) begin
                            r_min2 <= in_mag;
                        end
                        r_sgn <= r_sgn ^ in_sgn;
                        r_cnt <= r_cnt + IDX_W'(1);
                        if (w_last_beat) begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACC);
    assign out_valid = (r_state == ST_HOLD);
    assign busy      = (r_state != ST_IDLE);
    assign min1      = r_min1;
    assign min2      = r_min2;
    assign idx       = r_idx;
    assign sgn_prod  = r_sgn;
    assign err       = r_err;

endmodule

// File: tb/tb_cnu_min_seq.sv
// ----------------------------------------------------------------------------
// tb_cnu_min_seq
// Directed and randomized rows for cnu_min_seq. Expected results come from a
// reference that sorts the row's magnitudes and scans for the first minimum.
// Inputs change just after the falling edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_cnu_min_seq;

    localparam int DATA_W = 9;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [IDX_W:0]    deg;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_mag;
    logic              in_sgn;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] min1;
    logic [DATA_W-1:0] min2;
    logic [IDX_W-1:0]  idx;
    logic              sgn_prod;
    logic              busy;
    logic              err;

    int vectors = 0;
    int miscompares = 0;

    int unsigned b_mag [8];
    bit          b_sgn [8];
    int unsigned e_min1, e_min2, e_idx;
    bit          e_sgn;

    cnu_min_seq #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .deg(deg),
        .in_valid(in_valid), .in_ready(in_ready), .in_mag(in_mag), .in_sgn(in_sgn),
        .out_valid(out_valid), .out_ready(out_ready),
        .min1(min1), .min2(min2), .idx(idx), .sgn_prod(sgn_prod),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    // Reference: min1 is the smallest value, idx its first position, min2 the
    // second entry of the sorted multiset, sign the parity of all sign bits.
    task automatic model(input int n);
        int unsigned s [8];
        int unsigned t;
        e_min1 = b_mag[0];
        e_idx  = 0;
        e_sgn  = 1'b0;
        for (int i = 0; i < n; i++) begin
            s[i] = b_mag[i];
            e_sgn = e_sgn ^ b_sgn[i];
            if (b_mag[i] < e_min1) begin
                e_min1 = b_mag[i];
                e_idx  = i;
            end
        end
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n - 1 - i; j++) begin
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
            end
        end
        e_min2 = s[1];
    endtask

    task automatic check_result(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " min1"}, 32'(min1), e_min1);
        chk({tag, " min2"}, 32'(min2), e_min2);
        chk({tag, " idx"}, 32'(idx), e_idx);
        chk({tag, " sgn_prod"}, 32'(sgn_prod), 32'(e_sgn));
    endtask

    // One full row: start, beats with gap_lo..gap_hi idle cycles before each,
    // `stall` cycles of out_ready low in HOLD, then the handshake.
    task automatic run_row(input string tag, input int n, input int gap_lo,
                           input int gap_hi, input int stall, input bit noise);
        model(n);
        start = 1'b1;
        deg   = (IDX_W+1)'(n);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " acc busy"}, 32'(busy), 32'd1);
        chk({tag, " acc in_ready"}, 32'(in_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap_hi, gap_lo)) begin
                in_valid = 1'b0;
                in_mag   = DATA_W'($urandom_range(511, 0));
                if (noise) begin
                    start = 1'b1;
                    deg   = (IDX_W+1)'($urandom_range(15, 0));
                end
                @(negedge clk);
                start = 1'b0;
                chk({tag, " gap err"}, 32'(err), 32'd0);
                chk({tag, " gap in_ready"}, 32'(in_ready), 32'd1);
            end
            in_valid = 1'b1;
            in_mag   = DATA_W'(b_mag[i]);
            in_sgn   = b_sgn[i];
            @(negedge clk);
            in_valid = 1'b0;
            if (i < n - 1) chk({tag, " early out_valid"}, 32'(out_valid), 32'd0);
            chk({tag, " beat in_ready"}, 32'(in_ready), 32'(i < n - 1));
        end
        check_result({tag, " result"});
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_mag    = DATA_W'($urandom_range(511, 0));
            if (noise) begin
                start = 1'b1;
                deg   = (IDX_W+1)'(2);
            end
            @(negedge clk);
            chk({tag, " hold err"}, 32'(err), 32'd0);
            check_result({tag, " hold"});
        end
        start     = noise;
        deg       = (IDX_W+1)'(2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk({tag, " done out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " done busy"}, 32'(busy), 32'd0);
        chk({tag, " done err"}, 32'(err), 32'd0);
        @(negedge clk);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    task automatic bad_start(input int d);
        start = 1'b1;
        deg   = (IDX_W+1)'(d);
        @(negedge clk);
        start = 1'b0;
        chk("bad err pulse", 32'(err), 32'd1);
        chk("bad busy", 32'(busy), 32'd0);
        chk("bad in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bad err clear", 32'(err), 32'd0);
        chk("bad busy after", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; deg = '0; in_valid = 1'b0;
        in_mag = '0; in_sgn = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst min1", 32'(min1), 32'd511);
        chk("rst min2", 32'(min2), 32'd511);
        chk("rst idx", 32'(idx), 32'd0);
        chk("rst sgn", 32'(sgn_prod), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // deg=4 with a tie on the minimum
        b_mag[0] = 20; b_mag[1] = 7; b_mag[2] = 15; b_mag[3] = 7;
        b_sgn[0] = 1;  b_sgn[1] = 0; b_sgn[2] = 1;  b_sgn[3] = 1;
        run_row("tie4", 4, 0, 0, 0, 1'b0);
        chk("tie4 const min1", e_min1, 32'd7);
        chk("tie4 const idx", e_idx, 32'd1);

        // deg=8 descending, continuous beats: out_valid first at cycle 9
        for (int i = 0; i < 8; i++) begin
            b_mag[i] = 8 - i;
            b_sgn[i] = 0;
        end
        run_row("desc8", 8, 0, 0, 1, 1'b0);

        // illegal degrees
        bad_start(1);
        bad_start(9);
        bad_start(0);
        bad_start(15);

        // deg=2 with 3-cycle gaps, long HOLD with start pulses
        b_mag[0] = 5; b_mag[1] = 3; b_sgn[0] = 0; b_sgn[1] = 1;
        run_row("gap2", 2, 3, 3, 5, 1'b1);

        // reset mid-row after two accepted beats
        start = 1'b1; deg = (IDX_W+1)'(4);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_mag = DATA_W'(i + 1); in_sgn = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst min1", 32'(min1), 32'd511);
        chk("midrst min2", 32'(min2), 32'd511);
        chk("midrst sgn", 32'(sgn_prod), 32'd0);
        @(negedge clk);
        b_mag[0] = 100; b_mag[1] = 100; b_sgn[0] = 1; b_sgn[1] = 0;
        run_row("postrst", 2, 0, 0, 0, 1'b0);

        // randomized rows, some with narrow magnitude range to force ties
        for (int r = 0; r < 40; r++) begin
            int n;
            int hi;
            n  = $urandom_range(8, 2);
            hi = ($urandom_range(1, 0) == 1) ? 7 : 511;
            for (int i = 0; i < n; i++) begin
                b_mag[i] = $urandom_range(hi, 0);
                b_sgn[i] = 1'($urandom_range(1, 0));
            end
            run_row("rand", n, 0, $urandom_range(2, 0), $urandom_range(3, 0),
                    1'($urandom_range(1, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
